cache_datapath: RTL and testbench

Direct-mapped cache array and hit logic sitting directly downstream of the cache controller FSM. Consumes its `address`/`read`/`write` strobes, returns `HMbar` (1 = hit) combinationally, and on `write` fills a 4-word line from main memory through a ready-qualified read port. Keeps access and hit counters for hit-rate measurement.

---
 rtl/cache_datapath.sv | 136 +++++++++++++
 tb/tb_cache_datapath.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_datapath.sv
// Direct-mapped cache array with hit logic, 4-word line fill engine
// and saturating access/hit counters.
module cache_datapath #(
   parameter int WORDS_PER_LINE = 4,
   parameter int LINES          = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [14:0] address,
   input  logic        read,
   input  logic        write,
   output logic        HMbar,
   output logic [31:0] data_out,
   output logic        busy,
   output logic        fill_done,
   output logic [14:0] mem_addr,
   output logic        mem_rd,
   input  logic [31:0] mem_data,
   input  logic        mem_ready,
   output logic [15:0] access_count,
   output logic [15:0] hit_count
);

   localparam int OW = $clog2(WORDS_PER_LINE);
   localparam int IW = $clog2(LINES);
   localparam int TW = 15 - IW - OW;
   localparam int DW = IW + OW;

   typedef enum logic {IDLE, FILL} state_t;

   state_t             state_q, state_d;
   logic [TW-1:0]      ftag_q, ftag_d;
   logic [IW-1:0]      fidx_q, fidx_d;
   logic [OW-1:0]      beat_q, beat_d;
   logic               done_q, done_d;
   logic [15:0]        acc_q, acc_d;
   logic [15:0]        hit_q, hit_d;
   logic [LINES-1:0]   valid_q, valid_d;

   logic [TW-1:0]      tag_mem  [LINES];
   logic [31:0]        data_mem [LINES*WORDS_PER_LINE];

   logic [TW-1:0]      a_tag;
   logic [IW-1:0]      a_idx;
   logic [OW-1:0]      a_off;
   logic               last_beat;
   logic               beat_we;

   assign a_tag     = address[14 -: TW];
   assign a_idx     = address[OW +: IW];
   assign a_off     = address[OW-1:0];
   assign last_beat = (beat_q == OW'(WORDS_PER_LINE - 1));
   assign beat_we   = (state_q == FILL) && mem_ready;

   // Lookup depends on state register only, so no loop through busy.
   assign HMbar = valid_q[a_idx]
               && (tag_mem[a_idx] == a_tag)
               && (state_q == IDLE);
   assign data_out = HMbar ? data_mem[DW'({a_idx, a_off})] : 32'h0;

   assign fill_done    = done_q;
   assign access_count = acc_q;
   assign hit_count    = hit_q;

   always_comb begin
      state_d  = state_q;
      ftag_d   = ftag_q;
      fidx_d   = fidx_q;
      beat_d   = beat_q;
      acc_d    = acc_q;
      hit_d    = hit_q;
      valid_d  = valid_q;
      done_d   = 1'b0;
      busy     = 1'b0;
      mem_rd   = 1'b0;
      mem_addr = '0;
      unique case (state_q)
         IDLE: begin
            if (write) begin
               ftag_d         = a_tag;
               fidx_d         = a_idx;
               beat_d         = '0;
               valid_d[a_idx] = 1'b0;
               state_d        = FILL;
            end else if (read) begin
               if (acc_q != 16'hFFFF) acc_d = acc_q + 16'd1;
               if (HMbar && hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
            end
         end
         FILL: begin
            busy     = 1'b1;
            mem_rd   = 1'b1;
            mem_addr = {ftag_q, fidx_q, beat_q};
            if (mem_ready) begin
               beat_d = beat_q + 1'b1;
               if (last_beat) begin
                  valid_d[fidx_q] = 1'b1;
                  done_d          = 1'b1;
                  state_d         = IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ftag_q  <= '0;
         fidx_q  <= '0;
         beat_q  <= '0;
         done_q  <= 1'b0;
         acc_q   <= '0;
         hit_q   <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         ftag_q  <= ftag_d;
         fidx_q  <= fidx_d;
         beat_q  <= beat_d;
         done_q  <= done_d;
         acc_q   <= acc_d;
         hit_q   <= hit_d;
         valid_q <= valid_d;
      end
   end

   // Tag/data arrays carry no reset; validity alone guards them.
   always_ff @(posedge clk) begin
      if (beat_we) begin
         data_mem[DW'({fidx_q, beat_q})] <= mem_data;
         if (last_beat) tag_mem[fidx_q] <= ftag_q;
      end
   end

endmodule

// File: tb/tb_cache_datapath.sv
// Randomized bench for cache_datapath against a transaction-level
// cache model, plus directed scenarios with literal expectations.
module tb_cache_datapath;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [14:0] address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic        HMbar;
   logic [31:0] data_out;
   logic        busy;
   logic        fill_done;
   logic [14:0] mem_addr;
   logic        mem_rd;
   logic [31:0] mem_data;
   logic        mem_ready = 1'b1;
   logic [15:0] access_count;
   logic [15:0] hit_count;
   logic [31:0] key = '0;

   int n_chk  = 0;
   int n_fail = 0;

   cache_datapath dut (
      .clk(clk), .rst(rst), .address(address), .read(read),
      .write(write), .HMbar(HMbar), .data_out(data_out),
      .busy(busy), .fill_done(fill_done), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .access_count(access_count), .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(logic [14:0] a, logic [31:0] k);
      return (32'hA0 + {17'h0, a} - 32'h400) ^ k;
   endfunction

   assign mem_data = memf(mem_addr, key);

   // Model: cache contents plus one outstanding line-fill transaction.
   bit          m_valid [1024];
   bit [2:0]    m_tag   [1024];
   bit [31:0]   m_data  [4096];
   int          m_acc, m_hit;
   bit          m_fill, m_done;
   int          m_line, m_beats;
   bit [2:0]    m_ftag;

   task automatic model_reset();
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_acc = 0; m_hit = 0; m_fill = 0; m_done = 0; m_beats = 0;
   endtask

   function automatic bit exp_hit(logic [14:0] a);
      int li = int'(a[11:2]);
      return !m_fill && m_valid[li] && m_tag[li] == a[14:12];
   endfunction

   function automatic logic [14:0] exp_maddr();
      if (!m_fill) return 15'h0;
      return 15'({m_ftag, 10'(m_line), 2'(m_beats)});
   endfunction

   task automatic model_step();
      bit h;
      if (rst) begin model_reset(); return; end
      h = exp_hit(address);
      m_done = 0;
      if (m_fill) begin
         if (mem_ready) begin
            m_data[m_line*4 + m_beats] = memf(exp_maddr(), key);
            m_beats++;
            if (m_beats == 4) begin
               m_valid[m_line] = 1; m_tag[m_line] = m_ftag;
               m_fill = 0; m_done = 1; m_beats = 0;
            end
         end
      end else if (write) begin
         m_fill = 1; m_line = int'(address[11:2]);
         m_ftag = address[14:12]; m_beats = 0;
         m_valid[m_line] = 0;
      end else if (read) begin
         if (m_acc < 65535) m_acc++;
         if (h && m_hit < 65535) m_hit++;
      end
   endtask

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   task automatic check_all();
      bit h = exp_hit(address);
      chk("HMbar", 32'(HMbar), 32'(h));
      chk("data_out", data_out,
          h ? m_data[int'(address[11:0])] : 32'h0);
      chk("busy", 32'(busy), 32'(m_fill));
      chk("mem_rd", 32'(mem_rd), 32'(m_fill));
      chk("mem_addr", 32'(mem_addr), 32'(exp_maddr()));
      chk("fill_done", 32'(fill_done), 32'(m_done));
      chk("access_count", 32'(access_count), 32'(m_acc));
      chk("hit_count", 32'(hit_count), 32'(m_hit));
   endtask

   task automatic tick();
      #1 check_all();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic wait_idle(string n);
      int t = 0;
      while (busy && t < 50) begin tick(); t++; end
      if (t >= 50) chk({n, "_timeout"}, 32'(busy), 32'h0);
   endtask

   task automatic do_fill(logic [14:0] a);
      read = 0; write = 0; mem_ready = 1;
      wait_idle("pre_fill");
      address = a; write = 1;
      tick();
      write = 0;
      wait_idle("fill");
      tick();
   endtask

   task automatic rd(logic [14:0] a);
      address = a; read = 1; write = 0;
      tick();
      read = 0;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1 check_all();
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_acc", 32'(access_count), 32'h0);
      rst = 0;
      tick();

      rd(15'h0400);
      chk("miss_HMbar", 32'(HMbar), 32'h0);
      chk("miss_acc", 32'(access_count), 32'd1);
      chk("miss_hits", 32'(hit_count), 32'd0);

      address = 15'h0401; write = 1;
      tick();
      write = 0;
      for (int i = 0; i < 4; i++) begin
         chk("fill_addr", 32'(mem_addr), 32'h400 + i);
         tick();
      end
      chk("fill_done_lat", 32'(fill_done), 32'h1);
      chk("fill_busy_low", 32'(busy), 32'h0);

      rd(15'h0402);
      chk("hit_HMbar", 32'(HMbar), 32'h1);
      chk("hit_data", data_out, 32'hA2);
      chk("hit_count1", 32'(hit_count), 32'd1);

      do_fill(15'h1400);
      rd(15'h0400);
      chk("conf_miss", 32'(HMbar), 32'h0);
      rd(15'h1400);
      chk("conf_hit", 32'(HMbar), 32'h1);
      chk("conf_data", data_out, 32'h10A0);

      address = 15'h0800; write = 1;
      tick();
      write = 0;
      tick();
      tick();
      mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         chk("stall_addr", 32'(mem_addr), 32'h802);
         read = (i != 1); write = (i == 1);
         address = 15'h1400;
         tick();
      end
      read = 0; write = 0; mem_ready = 1;
      tick();
      tick();
      chk("stall_done", 32'(fill_done), 32'h1);
      chk("stall_acc", 32'(access_count), 32'd4);
      chk("stall_hits", 32'(hit_count), 32'd2);

      address = 15'h0C00; read = 1; write = 1;
      tick();
      read = 0; write = 0;
      chk("rw_busy", 32'(busy), 32'h1);
      chk("rw_acc", 32'(access_count), 32'd4);
      wait_idle("rw");
      tick();

      address = 15'h1000; write = 1;
      tick();
      write = 0;
      tick();
      tick();
      rst = 1;
      model_reset();
      #1;
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_rd", 32'(mem_rd), 32'h0);
      tick();
      rst = 0;
      tick();
      address = 15'h1000;
      #1 chk("mid_rst_miss", 32'(HMbar), 32'h0);
      chk("mid_rst_nodone", 32'(fill_done), 32'h0);
      tick();

      for (int c = 0; c < 3000; c++) begin
         address = 15'({$urandom_range(7, 0), 8'h0, 2'($urandom_range(3, 0)),
                       2'($urandom_range(3, 0))});
         if ($urandom_range(3, 0) == 0) address = 15'($urandom);
         read = ($urandom_range(1, 0) == 1);
         write = ($urandom_range(9, 0) == 0);
         mem_ready = ($urandom_range(9, 0) < 7);
         key = $urandom;
         tick();
      end
      read = 0; write = 0; key = 0;

      do_fill(15'h2000);
      for (int c = 0; c < 65540; c++) rd(15'h2001);
      chk("sat_acc", 32'(access_count), 32'hFFFF);
      chk("sat_hits", 32'(hit_count), 32'hFFFF);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
